// File: rtl/ekey_refresh_seq_pkg.sv
// Shared definitions for the EKEY refresh sequencer: region and ROM window
// defaults (also consumed by the EKEY write-protection monitor), FSM state
// encoding, and the trusted-ROM range helper.
package ekey_refresh_seq_pkg;

    localparam logic [15:0] EKEY_BASE = 16'h0230;
    localparam logic [15:0] EKEY_SIZE = 16'h001F;
    localparam logic [15:0] SMEM_BASE = 16'hA000;
    localparam logic [15:0] SMEM_SIZE = 16'h4000;

    // Index of the last byte of the region (region length is 1..255).
    localparam logic [7:0] EKEY_LAST_IDX = EKEY_SIZE[7:0] - 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_ZERO = 2'd2,
        ST_DONE = 2'd3
    } ekey_state_e;

    // True when pc lies in SMEM_BASE .. SMEM_BASE+SMEM_SIZE-2. Computed in
    // 17 bits so a window ending at the top of the map cannot wrap.
    function automatic logic pc_in_rom(input logic [15:0] pc);
        logic [16:0] lo;
        logic [16:0] hi;
        lo = {1'b0, SMEM_BASE};
        hi = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;
        return ({1'b0, pc} >= lo) && ({1'b0, pc} <= hi);
    endfunction

    // Data-memory byte address of region byte idx.
    function automatic logic [15:0] ekey_addr(input logic [7:0] idx);
        return EKEY_BASE + {8'h00, idx};
    endfunction

endpackage

// File: rtl/ekey_refresh_seq_if.sv
// Entropy handshake and data-memory byte-write side port of the EKEY
// refresh sequencer. master = sequencer, slave = RNG / memory side.
interface ekey_refresh_seq_if;
    logic        rng_valid;
    logic [7:0]  rng_data;
    logic        rng_ready;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;

    modport master (
        input  rng_valid, rng_data,
        output rng_ready, mem_wen, mem_addr, mem_din
    );

    modport slave (
        output rng_valid, rng_data,
        input  rng_ready, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/ekey_refresh_seq_idx_cnt.sv
// 8-bit byte index for the EKEY region. Clear wins over enable; o_last flags
// the final region byte. Shared by the FILL and ZERO phases.
module ekey_refresh_seq_idx_cnt
    import ekey_refresh_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [7:0] o_idx,
    output logic       o_last
);

    logic [7:0] r_idx;

    // Index register: cleared on request, advanced once per written byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 8'd0;
        end else if (i_clr) begin
            r_idx <= 8'd0;
        end else if (i_en) begin
            r_idx <= r_idx + 8'd1;
        end else begin
            r_idx <= r_idx;
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == EKEY_LAST_IDX);

endmodule

// File: rtl/ekey_refresh_seq.sv
// EKEY refresh sequencer: refills the ephemeral-key region from the entropy
// source when triggered from trusted ROM, yielding the byte-write port to CPU
// and DMA traffic and aborting if execution leaves ROM.
// Optional build macro EKEY_REFRESH_ZEROIZE_EN: an abort wipes the whole
// region with zeros before returning to IDLE.
module ekey_refresh_seq
    import ekey_refresh_seq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               i_pc,
    input  logic                      i_start,
    input  logic                      i_cpu_data_en,
    input  logic                      i_dma_en,
    ekey_refresh_seq_if.master        bus,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_abort
);

    ekey_state_e r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_abort;

    logic        w_bus_free;
    logic        w_in_rom;
    logic        w_fill_wr;
    logic        w_zero_wr;
    logic        w_wr;
    logic        w_abort_det;
    logic        w_clr;
    logic        w_last;
    logic [7:0]  w_idx;

    assign w_bus_free  = !i_cpu_data_en && !i_dma_en;
    assign w_in_rom    = pc_in_rom(i_pc);
    assign w_fill_wr   = (r_state == ST_FILL) && bus.rng_valid && w_bus_free && w_in_rom;
    // Leaving ROM during FILL blocks the write of that cycle and aborts.
    assign w_abort_det = (r_state == ST_FILL) && !w_in_rom;
`ifdef EKEY_REFRESH_ZEROIZE_EN
    assign w_zero_wr   = (r_state == ST_ZERO) && w_bus_free;
`else
    assign w_zero_wr   = 1'b0;
`endif
    assign w_wr        = w_fill_wr || w_zero_wr;
    // Index restarts at 0 for every refresh and again for the wipe pass.
    assign w_clr       = (r_state == ST_IDLE) || w_abort_det;

    ekey_refresh_seq_idx_cnt u_idx_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_wr),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    // Handshake and write port follow the current state combinationally.
    always_comb begin
        bus.rng_ready = (r_state == ST_FILL) && w_bus_free && w_in_rom;
        bus.mem_wen   = w_wr;
        if (w_wr) begin
            bus.mem_addr = ekey_addr(w_idx);
        end else begin
            bus.mem_addr = 16'h0000;
        end
        if (w_fill_wr) begin
            bus.mem_din = bus.rng_data;
        end else begin
            bus.mem_din = 8'h00;
        end
    end

    // Sequencer FSM with registered busy/done/abort status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && w_in_rom) begin
                        r_state <= ST_FILL;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (w_abort_det) begin
                        r_abort <= 1'b1;
`ifdef EKEY_REFRESH_ZEROIZE_EN
                        r_state <= ST_ZERO;
                        r_busy  <= 1'b1;
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else if (w_fill_wr && w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_FILL;
                        r_busy  <= 1'b1;
                    end
                end
`ifdef EKEY_REFRESH_ZEROIZE_EN
                ST_ZERO: begin
                    if (w_zero_wr && w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_ZERO;
                        r_busy  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_abort = r_abort;

endmodule

// File: tb/tb_ekey_refresh_seq.sv
// Self-checking bench for ekey_refresh_seq. Expected write streams, done/abort
// timing and busy length are derived from the refresh rules by counting bytes
// accepted per cycle of a randomized stall/valid/pc schedule.
module tb_ekey_refresh_seq;

    localparam int          NC     = 200;
    localparam logic [15:0] E_BASE = 16'h0230;
    localparam int          E_SIZE = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        start;
    logic        cpu_en;
    logic        dma_en;
    logic        busy;
    logic        done;
    logic        abort;

    ekey_refresh_seq_if bus();

    ekey_refresh_seq dut (
        .clk           (clk),
        .rst           (rst),
        .i_pc          (pc),
        .i_start       (start),
        .i_cpu_data_en (cpu_en),
        .i_dma_en      (dma_en),
        .bus           (bus),
        .o_busy        (busy),
        .o_done        (done),
        .o_abort       (abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus schedule (index = cycle after the start edge).
    bit        stall_cpu [NC];
    bit        stall_dma [NC];
    bit        valid_a   [NC];
    bit        start_a   [NC];
    logic [7:0] src      [64];
    int         src_idx;

    // Expected results of one refresh.
    logic [15:0] exp_addr [$];
    logic [7:0]  exp_data [$];
    int          exp_cyc  [$];
    int          exp_done;
    int          exp_abort;
    int          exp_busy;

    // Monitor log, owned by the monitor process.
    int          mon_cyc  = 0;
    int          busy_cnt = 0;
    int          viol_cnt = 0;
    logic [15:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    int          wr_cyc_q  [$];
    int          done_q    [$];
    int          abort_q   [$];

    // Record every write, status pulse and protocol violation mid-cycle.
    always @(negedge clk) begin
        mon_cyc <= mon_cyc + 1;
        if (bus.mem_wen) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_din);
            wr_cyc_q.push_back(mon_cyc + 1);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_q.push_back(mon_cyc + 1);
        if (abort) abort_q.push_back(mon_cyc + 1);
        if (!bus.mem_wen && (bus.mem_addr != 16'h0000 || bus.mem_din != 8'h00))
            viol_cnt <= viol_cnt + 1;
        else if (bus.rng_ready && (cpu_en || dma_en || pc < 16'hA000 || pc > 16'hDFFE || !busy))
            viol_cnt <= viol_cnt + 1;
    end

    // Expected outcome from the schedule: bytes are taken in order whenever
    // the bus is free, entropy is valid and pc is in ROM; leaving ROM aborts.
    task automatic build_expect(input int leave);
        int phase;   // 0 filling, 1 done cycle, 2 wiping, 3 finished
        int nfill;
        int nzero;
        exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
        exp_done = -1; exp_abort = -1; exp_busy = 0;
        phase = 0; nfill = 0; nzero = 0;
        for (int c = 1; c < NC; c++) begin
            if (phase == 0) begin
                exp_busy++;
                if (leave != 0 && c >= leave) begin
                    exp_abort = c + 1;
`ifdef EKEY_REFRESH_ZEROIZE_EN
                    phase = 2;
`else
                    phase = 3;
`endif
                end else if (!stall_cpu[c] && !stall_dma[c] && valid_a[c]) begin
                    exp_addr.push_back(E_BASE + 16'(nfill));
                    exp_data.push_back(src[nfill]);
                    exp_cyc.push_back(c);
                    nfill++;
                    if (nfill == E_SIZE) begin
                        exp_done = c + 1;
                        phase = 1;
                    end
                end
            end else if (phase == 1) begin
                exp_busy++;
                phase = 3;
            end else if (phase == 2) begin
                exp_busy++;
                if (!stall_cpu[c] && !stall_dma[c]) begin
                    exp_addr.push_back(E_BASE + 16'(nzero));
                    exp_data.push_back(8'h00);
                    exp_cyc.push_back(c);
                    nzero++;
                    if (nzero == E_SIZE) phase = 3;
                end
            end
        end
    endtask

    // Pulse start for one edge with the given pc; base = cycle count at that edge.
    task automatic start_pulse(input logic [15:0] spc, output int base);
        src_idx = 0;
        bus.rng_data = src[0];
        pc = spc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base = mon_cyc;
    endtask

    // Drive cycles 1..ncyc from the schedule; pc leaves ROM from cycle leave.
    task automatic run_refresh(input int leave, input int ncyc);
        bit consumed;
        for (int c = 1; c <= ncyc; c++) begin
            cpu_en        = stall_cpu[c];
            dma_en        = stall_dma[c];
            bus.rng_valid = valid_a[c];
            start         = start_a[c];
            pc            = (leave != 0 && c >= leave) ? 16'h4000 : 16'hA100;
            bus.rng_data  = src[src_idx];
            @(negedge clk);
            consumed = bus.rng_ready && bus.rng_valid;
            @(posedge clk); #1;
            if (consumed && src_idx < 63) src_idx++;
        end
        cpu_en = 1'b0; dma_en = 1'b0; bus.rng_valid = 1'b0; start = 1'b0;
        pc = 16'hA100;
    endtask

    task automatic clear_schedule();
        for (int c = 0; c < NC; c++) begin
            stall_cpu[c] = 1'b0; stall_dma[c] = 1'b0; valid_a[c] = 1'b1; start_a[c] = 1'b0;
        end
        for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = 16'hA100; start = 1'b0; cpu_en = 1'b0; dma_en = 1'b0;
        bus.rng_valid = 1'b0; bus.rng_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", abort); end
        checks++; if (bus.mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", bus.mem_wen); end
        checks++; if (bus.rng_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.rng_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    // Scenario table: 0 normal (+start while busy), 1 alternate CPU stalls,
    // 2 abort after 10 bytes, 3 abort on the final write, 4..9 random.
    task automatic test_refresh_table();
        for (int k = 0; k < 10; k++) begin
            int leave; int n0; int d0; int a0; int b0; int v0; int base; int nw;
            clear_schedule();
            leave = 0;
            case (k)
                0: begin
                    for (int i = 0; i < 64; i++) src[i] = 8'(i + 1);
                    for (int c = 5; c <= 8; c++) start_a[c] = 1'b1;
                end
                1: for (int c = 0; c < NC; c++) stall_cpu[c] = (c % 2 == 0);
                2: leave = 11;
                3: leave = E_SIZE;
                default: begin
                    for (int c = 0; c < NC; c++) begin
                        stall_cpu[c] = ($urandom_range(0, 3) == 0);
                        stall_dma[c] = ($urandom_range(0, 6) == 0);
                        valid_a[c]   = ($urandom_range(0, 9) < 7);
                    end
                    leave = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 45));
                end
            endcase
            build_expect(leave);
            n0 = wr_addr_q.size(); d0 = done_q.size(); a0 = abort_q.size();
            b0 = busy_cnt; v0 = viol_cnt;
            start_pulse(16'hA100, base);
            run_refresh(leave, NC - 1);
            @(negedge clk);
            nw = wr_addr_q.size() - n0;
            checks++;
            if (nw !== exp_addr.size()) begin
                errors++; $display("FAIL s%0d_write_count: got %0d want %0d", k, nw, exp_addr.size());
            end else begin
                for (int i = 0; i < nw; i++) begin
                    checks++;
                    if (wr_addr_q[n0+i] !== exp_addr[i] || wr_data_q[n0+i] !== exp_data[i] ||
                        wr_cyc_q[n0+i] - base !== exp_cyc[i]) begin
                        errors++;
                        $display("FAIL s%0d_write%0d: got %h<=%h @%0d want %h<=%h @%0d", k, i,
                                 wr_addr_q[n0+i], wr_data_q[n0+i], wr_cyc_q[n0+i] - base,
                                 exp_addr[i], exp_data[i], exp_cyc[i]);
                    end
                end
            end
            checks++;
            if ((done_q.size() - d0) !== ((exp_done < 0) ? 0 : 1) ||
                (exp_done >= 0 && done_q[d0] - base !== exp_done)) begin
                errors++; $display("FAIL s%0d_done: got %0d pulses want cycle %0d", k, done_q.size() - d0, exp_done);
            end
            checks++;
            if ((abort_q.size() - a0) !== ((exp_abort < 0) ? 0 : 1) ||
                (exp_abort >= 0 && abort_q[a0] - base !== exp_abort)) begin
                errors++; $display("FAIL s%0d_abort: got %0d pulses want cycle %0d", k, abort_q.size() - a0, exp_abort);
            end
            checks++;
            if (busy_cnt - b0 !== exp_busy) begin
                errors++; $display("FAIL s%0d_busy_len: got %0d want %0d", k, busy_cnt - b0, exp_busy);
            end
            checks++;
            if (viol_cnt - v0 !== 0) begin
                errors++; $display("FAIL s%0d_protocol: got %0d violations want 0", k, viol_cnt - v0);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL s%0d_idle_end: busy got %b want 0", k, busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_untrusted();
        int n0; int b0; int d0; int a0; int base;
        clear_schedule();
        n0 = wr_addr_q.size(); b0 = busy_cnt; d0 = done_q.size(); a0 = abort_q.size();
        start_pulse(16'h4000, base);
        run_refresh(1, 40);
        checks++;
        if (wr_addr_q.size() - n0 !== 0 || busy_cnt - b0 !== 0 ||
            done_q.size() - d0 !== 0 || abort_q.size() - a0 !== 0) begin
            errors++;
            $display("FAIL untrusted_start: writes %0d busy %0d done %0d abort %0d want all 0",
                     wr_addr_q.size() - n0, busy_cnt - b0, done_q.size() - d0, abort_q.size() - a0);
        end
    endtask

    task automatic test_reset_mid();
        int n0; int base;
        clear_schedule();
        start_pulse(16'hA100, base);
        run_refresh(0, 5);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || abort !== 1'b0 || bus.mem_wen !== 1'b0 ||
            bus.rng_ready !== 1'b0 || bus.mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy %b done %b abort %b wen %b ready %b addr %h want 0",
                     busy, done, abort, bus.mem_wen, bus.rng_ready, bus.mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n0 = wr_addr_q.size();
        start_pulse(16'hA100, base);
        run_refresh(0, 40);
        checks++;
        if (wr_addr_q.size() - n0 !== E_SIZE || wr_addr_q[n0] !== E_BASE || wr_data_q[n0] !== src[0]) begin
            errors++;
            $display("FAIL reset_mid_restart: got %0d writes first %h<=%h want %0d first %h<=%h",
                     wr_addr_q.size() - n0, wr_addr_q[n0], wr_data_q[n0], E_SIZE, E_BASE, src[0]);
        end
    endtask

    initial begin
        test_reset();
        test_refresh_table();
        test_untrusted();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
